// File: rtl/clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// clock_mode_ctrl
//
// Control block for the time-of-day counter datapath. It produces the 1 Hz
// seconds strobe, debounces the two front-panel buttons and runs the mode FSM
// (RUN / SET_HR / SET_MIN). The datapath registers clock on clk and use the
// single-cycle enables from this block. There are no derived clocks.
//
// Ports
//   clk      in   system clock, all logic on the rising edge
//   rst      in   synchronous, active-high reset
//   btn_mode in   raw asynchronous mode button, active-high
//   btn_inc  in   raw asynchronous increment button, active-high
//   inc_sec  out  one-cycle enable: advance seconds (carry handled in datapath)
//   inc_min  out  one-cycle enable: advance minutes, no carry into hours
//   inc_hr   out  one-cycle enable: advance hours
//   clr_sec  out  one-cycle enable: zero seconds
//   mode     out  current FSM state: 00=RUN, 01=SET_HR, 10=SET_MIN
//   blink    out  blank toggle for the field being set, 0 in RUN
//
// Handshake: there is none. Every enable is a registered single-cycle pulse,
// and at most one of inc_sec/inc_min/inc_hr/clr_sec is high in any cycle.
// ---------------------------------------------------------------------------
module clock_mode_ctrl #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int BLINK_DIV    = 12_500_000,
    parameter int TIMEOUT_CYC  = 500_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       inc_hr,
    output logic       clr_sec,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PRE_W = (CLK_HZ > 1)       ? $clog2(CLK_HZ)       : 1;
    localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int BLK_W = (BLINK_DIV > 1)    ? $clog2(BLINK_DIV)    : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1)  ? $clog2(TIMEOUT_CYC)  : 1;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    // Button index 0 = mode, 1 = inc.
    logic [1:0] btn_raw;
    assign btn_raw = {btn_inc, btn_mode};

    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      db_lvl_q, db_lvl_d;
    logic [1:0]      db_prev_q, db_prev_d;
    logic [1:0]      press_q, press_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [BLK_W-1:0] blk_div_q, blk_div_d;
    logic             blink_q, blink_d;
    logic             inc_sec_q, inc_sec_d;
    logic             inc_min_q, inc_min_d;
    logic             inc_hr_q, inc_hr_d;
    logic             clr_sec_q, clr_sec_d;

    logic mode_press;
    logic inc_press;
    logic timeout_hit;
    logic set_entry;

    // -----------------------------------------------------------------------
    // Synchronizers, debounce and press detection
    // -----------------------------------------------------------------------
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_prev_d = db_lvl_q;
        // Press is one cycle behind the debounced rise so it comes from a flop.
        press_d   = db_lvl_q & ~db_prev_q;
        db_lvl_d  = db_lvl_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                // Accept the new level only after DEBOUNCE_CYC differing cycles.
                if (db_cnt_q[i] == DB_MAX) begin
                    db_lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    assign mode_press  = press_q[0];
    assign inc_press   = press_q[1];
    assign timeout_hit = (to_q == TO_MAX);

    // -----------------------------------------------------------------------
    // Mode FSM: next state and strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        inc_hr_d  = 1'b0;
        inc_min_d = 1'b0;
        clr_sec_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                // inc presses are ignored while running.
                if (mode_press) state_d = ST_SET_HR;
            end
            ST_SET_HR: begin
                // Priority: mode press, then inc press, then timeout.
                if (mode_press)       state_d  = ST_SET_MIN;
                else if (inc_press)   inc_hr_d = 1'b1;
                else if (timeout_hit) state_d  = ST_RUN;
            end
            ST_SET_MIN: begin
                if (mode_press) begin
                    state_d   = ST_RUN;
                    clr_sec_d = 1'b1;
                end else if (inc_press) begin
                    inc_min_d = 1'b1;
                end else if (timeout_hit) begin
                    // Timeout return leaves seconds untouched.
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign set_entry = (state_d != ST_RUN) && (state_d != state_q);

    // -----------------------------------------------------------------------
    // Prescaler, timeout and blink divider
    // -----------------------------------------------------------------------
    always_comb begin
        pre_d     = '0;
        inc_sec_d = 1'b0;
        // Counting only while staying in RUN makes the first second after a
        // set mode a full CLK_HZ cycles.
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (pre_q == PRE_MAX) begin
                inc_sec_d = 1'b1;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        to_d = '0;
        if (state_d != ST_RUN && !set_entry && !mode_press && !inc_press) begin
            to_d = to_q + TO_W'(1);
        end

        blk_div_d = '0;
        blink_d   = 1'b0;
        if (state_d != ST_RUN && !set_entry) begin
            if (blk_div_q == BLK_MAX) begin
                blink_d = ~blink_q;
            end else begin
                blk_div_d = blk_div_q + BLK_W'(1);
                blink_d   = blink_q;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_lvl_q    <= '0;
            db_prev_q   <= '0;
            press_q     <= '0;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
            state_q     <= ST_RUN;
            pre_q       <= '0;
            to_q        <= '0;
            blk_div_q   <= '0;
            blink_q     <= 1'b0;
            inc_sec_q   <= 1'b0;
            inc_min_q   <= 1'b0;
            inc_hr_q    <= 1'b0;
            clr_sec_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_lvl_q    <= db_lvl_d;
            db_prev_q   <= db_prev_d;
            press_q     <= press_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            state_q     <= state_d;
            pre_q       <= pre_d;
            to_q        <= to_d;
            blk_div_q   <= blk_div_d;
            blink_q     <= blink_d;
            inc_sec_q   <= inc_sec_d;
            inc_min_q   <= inc_min_d;
            inc_hr_q    <= inc_hr_d;
            clr_sec_q   <= clr_sec_d;
        end
    end

    assign inc_sec = inc_sec_q;
    assign inc_min = inc_min_q;
    assign inc_hr  = inc_hr_q;
    assign clr_sec = clr_sec_q;
    assign mode    = state_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clock_mode_ctrl
//
// Directed bench for clock_mode_ctrl with small parameters:
// CLK_HZ=10, DEBOUNCE_CYC=4, BLINK_DIV=3, TIMEOUT_CYC=40.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point (checks in the main flow) or on the falling edge (strobe monitor).
// ---------------------------------------------------------------------------
module tb_clock_mode_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic       inc_sec;
  logic       inc_min;
  logic       inc_hr;
  logic       clr_sec;
  logic [1:0] mode;
  logic       blink;

  int n_tests;
  int n_fail;
  int n_inc_sec;
  int n_inc_min;
  int n_inc_hr;
  int n_clr_sec;
  bit mon_en;

  clock_mode_ctrl #(
    .CLK_HZ      (10),
    .DEBOUNCE_CYC(4),
    .BLINK_DIV   (3),
    .TIMEOUT_CYC (40)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .inc_sec (inc_sec),
    .inc_min (inc_min),
    .inc_hr  (inc_hr),
    .clr_sec (clr_sec),
    .mode    (mode),
    .blink   (blink)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 ns after the last edge that sampled rst high.
  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Full press: held long enough to debounce, then released and settled.
  task automatic press(input bit is_inc);
    if (is_inc) btn_inc = 1'b1;
    else        btn_mode = 1'b1;
    tick(6);
    btn_inc  = 1'b0;
    btn_mode = 1'b0;
    tick(10);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mode"},    32'(mode),    32'd0);
    check({tag, "_inc_sec"}, 32'(inc_sec), 32'd0);
    check({tag, "_inc_min"}, 32'(inc_min), 32'd0);
    check({tag, "_inc_hr"},  32'(inc_hr),  32'd0);
    check({tag, "_clr_sec"}, 32'(clr_sec), 32'd0);
    check({tag, "_blink"},   32'(blink),   32'd0);
  endtask

  // strobe monitor: counts pulses, checks exclusivity and legal mode
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      n_inc_sec += int'(inc_sec);
      n_inc_min += int'(inc_min);
      n_inc_hr  += int'(inc_hr);
      n_clr_sec += int'(clr_sec);
      check("strobe_excl",
            ($countones({inc_sec, inc_min, inc_hr, clr_sec}) <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("mode_legal", (mode != 2'b11) ? 32'd1 : 32'd0, 32'd1);
    end
  end

  // watchdog
  initial begin
    #200_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hr0, min0, clr0, sec0;
    n_tests   = 0;
    n_fail    = 0;
    n_inc_sec = 0;
    n_inc_min = 0;
    n_inc_hr  = 0;
    n_clr_sec = 0;
    mon_en    = 1'b0;
    rst       = 1'b1;
    btn_mode  = 1'b0;
    btn_inc   = 1'b0;

    // 1: reset state and free-running seconds strobe
    do_reset();
    mon_en = 1'b1;
    check_all_zero("reset");
    for (int k = 1; k <= 35; k++) begin
      tick(1);
      check("t1_inc_sec", 32'(inc_sec), 32'(k % 10 == 0));
      check("t1_mode", 32'(mode), 32'd0);
    end
    check("t1_sec_count", 32'(n_inc_sec), 32'd3);
    check("t1_other_strobes", 32'(n_inc_hr + n_inc_min + n_clr_sec), 32'd0);

    // 2: mode press latency, prescaler frozen in SET_HR
    do_reset();
    sec0 = n_inc_sec;
    btn_mode = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick(1);
      check("t2_mode", 32'(mode), (j >= 8) ? 32'd1 : 32'd0);
      check("t2_inc_sec", 32'(inc_sec), 32'd0);
    end
    btn_mode = 1'b0;
    tick(20);
    check("t2_single_press", 32'(mode), 32'd1);
    check("t2_no_sec", 32'(n_inc_sec - sec0), 32'd0);

    // 3: hour and minute setting, exit with clr_sec, full first second
    hr0  = n_inc_hr;
    min0 = n_inc_min;
    clr0 = n_clr_sec;
    press(1'b1);
    press(1'b1);
    press(1'b1);
    check("t3_hr_pulses", 32'(n_inc_hr - hr0), 32'd3);
    check("t3_mode_hr", 32'(mode), 32'd1);
    press(1'b0);
    check("t3_mode_min", 32'(mode), 32'd2);
    press(1'b1);
    press(1'b1);
    check("t3_min_pulses", 32'(n_inc_min - min0), 32'd2);
    check("t3_hr_unchanged", 32'(n_inc_hr - hr0), 32'd3);
    btn_mode = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      tick(1);
      if (j == 6) btn_mode = 1'b0;
      if (j == 7) begin
        check("t3_mode_before", 32'(mode), 32'd2);
        check("t3_clr_before", 32'(clr_sec), 32'd0);
      end
      if (j == 8) begin
        check("t3_mode_run", 32'(mode), 32'd0);
        check("t3_clr_same_cycle", 32'(clr_sec), 32'd1);
      end
      if (j == 9) check("t3_clr_after", 32'(clr_sec), 32'd0);
      check("t3_first_sec", 32'(inc_sec), 32'(j == 18));
    end
    check("t3_clr_count", 32'(n_clr_sec - clr0), 32'd1);

    // 4: glitch rejection and simultaneous presses
    press(1'b0);
    press(1'b0);
    check("t4_mode_min", 32'(mode), 32'd2);
    hr0  = n_inc_hr;
    min0 = n_inc_min;
    clr0 = n_clr_sec;
    btn_inc = 1'b1;
    tick(3);
    btn_inc = 1'b0;
    tick(10);
    check("t4_glitch_no_min", 32'(n_inc_min - min0), 32'd0);
    check("t4_glitch_mode", 32'(mode), 32'd2);
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    tick(6);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick(10);
    check("t4_simul_mode", 32'(mode), 32'd0);
    check("t4_simul_no_min", 32'(n_inc_min - min0), 32'd0);
    check("t4_simul_no_hr", 32'(n_inc_hr - hr0), 32'd0);
    check("t4_simul_clr", 32'(n_clr_sec - clr0), 32'd1);

    // 5: blink pattern and timeout back to RUN
    do_reset();
    clr0 = n_clr_sec;
    btn_mode = 1'b1;
    tick(6);
    btn_mode = 1'b0;
    tick(2);
    for (int k = 0; k <= 42; k++) begin
      check("t5_mode", 32'(mode), (k < 40) ? 32'd1 : 32'd0);
      check("t5_blink", 32'(blink), (k < 40) ? 32'((k / 3) % 2) : 32'd0);
      check("t5_clr", 32'(clr_sec), 32'd0);
      tick(1);
    end
    check("t5_clr_count", 32'(n_clr_sec - clr0), 32'd0);

    // 6a: reset in SET_MIN with a released, pending press
    do_reset();
    press(1'b0);
    press(1'b0);
    check("t6_mode_min", 32'(mode), 32'd2);
    btn_mode = 1'b1;
    tick(3);
    btn_mode = 1'b0;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all_zero("t6_reset");
    tick(15);
    check("t6_press_lost", 32'(mode), 32'd0);

    // 6b: button still held through reset gives exactly one press
    press(1'b0);
    press(1'b0);
    check("t6b_mode_min", 32'(mode), 32'd2);
    btn_mode = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t6b_reset_mode", 32'(mode), 32'd0);
    tick(7);
    check("t6b_before_press", 32'(mode), 32'd0);
    tick(1);
    check("t6b_held_press", 32'(mode), 32'd1);
    btn_mode = 1'b0;
    tick(15);
    check("t6b_one_press", 32'(mode), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
